// File: rtl/pll_rst_pkg.sv
// -----------------------------------------------------------------------------
// pll_rst_pkg
// Shared definitions for the PLL lock-qualified reset sequencer.
//   state_t : 2-bit FSM state, encoding fixed so state_o can be decoded
//             directly by debug tooling (WAIT_LOCK=0, STABILIZE=1,
//             RELEASE=2, RUN=3).
// -----------------------------------------------------------------------------
package pll_rst_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

endpackage : pll_rst_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for slow CDC flags (level signals only).
// Both flops clear to 0 on a synchronous active-high reset.
// Ports:
//   i_clk : destination clock
//   i_rst : synchronous active-high reset
//   i_d   : asynchronous input flag
//   o_q   : flag synchronized to i_clk (two-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture: r_meta may go metastable, r_sync gets a full cycle to settle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Holds downstream logic in reset until the PLL lock flag has been stable for
// LOCK_STABLE_CYCLES cycles, then releases NUM_STAGES resets one at a time,
// STAGE_DELAY cycles apart (bit 0 first). Loss of lock or a soft request
// re-arms the sequence.
// Optional feature: define PLL_RST_LOSS_COUNT_EN to add a saturating
// lock-loss counter and its lock_loss_cnt output port.
// Ports:
//   clk           : PLL outclk_0
//   rst           : synchronous active-high reset
//   pll_locked    : PLL lock flag, asynchronous to clk
//   soft_rst_req  : single-cycle request to re-run the sequence
//   rst_out       : active-high stage resets (registered)
//   ready         : all stages released (registered)
//   state_o       : current FSM state, debug
//   lock_loss_cnt : saturating lock-loss count (PLL_RST_LOSS_COUNT_EN only)
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int NUM_STAGES         = 3,
    parameter int CNT_W              = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  ready,
    output logic [1:0]            state_o
`ifdef PLL_RST_LOSS_COUNT_EN
    ,
    output logic [CNT_W-1:0]      lock_loss_cnt
`endif
);

    // Counters are sized to their terminal value; STAGE_DELAY=1 still needs one bit.
    localparam int CNT_BITS  = $clog2(LOCK_STABLE_CYCLES);
    localparam int DCNT_BITS = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;

    localparam logic [CNT_BITS-1:0]   CNT_ZERO  = {CNT_BITS{1'b0}};
    localparam logic [CNT_BITS-1:0]   CNT_LAST  = CNT_BITS'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DCNT_BITS-1:0]  DCNT_ZERO = {DCNT_BITS{1'b0}};
    localparam logic [DCNT_BITS-1:0]  DCNT_LAST = DCNT_BITS'(STAGE_DELAY - 1);
    localparam logic [NUM_STAGES-1:0] RST_ALL   = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] RST_NONE  = {NUM_STAGES{1'b0}};
    // Pattern with only the top stage still in reset: the next drop is the last one.
    localparam logic [NUM_STAGES-1:0] RST_LAST  = NUM_STAGES'(1) << (NUM_STAGES - 1);

    logic w_locked_s;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_BITS-1:0]   r_cnt;
    logic [CNT_BITS-1:0]   w_cnt_nxt;
    logic [DCNT_BITS-1:0]  r_dcnt;
    logic [DCNT_BITS-1:0]  w_dcnt_nxt;
    logic [NUM_STAGES-1:0] r_rst_out;
    logic [NUM_STAGES-1:0] w_rst_out_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;

    logic w_cnt_done;
    logic w_dcnt_done;

    sync_2ff u_lock_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_cnt_done  = (r_cnt == CNT_LAST);
    assign w_dcnt_done = (r_dcnt == DCNT_LAST);

    // State register together with counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_WAIT_LOCK;
            r_cnt     <= CNT_ZERO;
            r_dcnt    <= DCNT_ZERO;
            r_rst_out <= RST_ALL;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dcnt    <= w_dcnt_nxt;
            r_rst_out <= w_rst_out_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Next-state and counter logic; lock loss has priority over a soft request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_locked_s) begin
                    w_state_nxt = ST_STABILIZE;
                end else begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (w_cnt_done) begin
                    w_state_nxt = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_dcnt_nxt  = DCNT_ZERO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_BITS'(1);
                end
            end
            ST_RELEASE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (soft_rst_req) begin
                    w_state_nxt = ST_STABILIZE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (w_dcnt_done) begin
                    w_dcnt_nxt = DCNT_ZERO;
                    if (r_rst_out == RST_LAST) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_RELEASE;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + DCNT_BITS'(1);
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (soft_rst_req) begin
                    w_state_nxt = ST_STABILIZE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
                w_cnt_nxt   = CNT_ZERO;
                w_dcnt_nxt  = DCNT_ZERO;
            end
        endcase
    end

    // Next values of the registered outputs. Stages drop by shifting a zero in
    // from bit 0, so bits can only deassert in ascending order.
    always_comb begin
        w_rst_out_nxt = r_rst_out;
        w_ready_nxt   = r_ready;
        case (r_state)
            ST_WAIT_LOCK: begin
                w_rst_out_nxt = RST_ALL;
                w_ready_nxt   = 1'b0;
            end
            ST_STABILIZE: begin
                if (w_locked_s && w_cnt_done) begin
                    w_rst_out_nxt = r_rst_out << 1;
                    w_ready_nxt   = (NUM_STAGES == 1);
                end else begin
                    w_rst_out_nxt = RST_ALL;
                    w_ready_nxt   = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!w_locked_s || soft_rst_req) begin
                    w_rst_out_nxt = RST_ALL;
                    w_ready_nxt   = 1'b0;
                end else if (w_dcnt_done) begin
                    w_rst_out_nxt = r_rst_out << 1;
                    w_ready_nxt   = (r_rst_out == RST_LAST);
                end else begin
                    w_rst_out_nxt = r_rst_out;
                    w_ready_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!w_locked_s || soft_rst_req) begin
                    w_rst_out_nxt = RST_ALL;
                    w_ready_nxt   = 1'b0;
                end else begin
                    w_rst_out_nxt = RST_NONE;
                    w_ready_nxt   = 1'b1;
                end
            end
            default: begin
                w_rst_out_nxt = RST_ALL;
                w_ready_nxt   = 1'b0;
            end
        endcase
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;
    assign state_o = r_state;

`ifdef PLL_RST_LOSS_COUNT_EN
    logic [CNT_W-1:0] r_lock_loss_cnt;
    logic             w_lock_lost;

    // Any non-idle state seeing locked_s low is exactly a lock-loss entry into WAIT_LOCK.
    assign w_lock_lost = (r_state != ST_WAIT_LOCK) && !w_locked_s;

    // Saturating lock-loss counter, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_loss_cnt <= {CNT_W{1'b0}};
        end else if (w_lock_lost && (r_lock_loss_cnt != {CNT_W{1'b1}})) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + CNT_W'(1);
        end else begin
            r_lock_loss_cnt <= r_lock_loss_cnt;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`endif

endmodule : pll_reset_sequencer

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Scenario bench for pll_reset_sequencer with LOCK_STABLE_CYCLES=8,
// STAGE_DELAY=4, NUM_STAGES=3, CNT_W=2. Expected (rst_out, ready, state)
// triples are queued with the clock edge after which they must hold; a
// monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int LSC = 8;
    localparam int SD  = 4;
    localparam int NS  = 3;
    localparam int CW  = 2;

    typedef struct {
        int         at;
        string      tag;
        logic [2:0] r;
        logic       rdy;
        logic [1:0] st;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          pll_locked;
    logic          soft_rst_req;
    logic [NS-1:0] rst_out;
    logic          ready;
    logic [1:0]    state_o;
`ifdef PLL_RST_LOSS_COUNT_EN
    logic [CW-1:0] lock_loss_cnt;
    int            exp_llc;
`endif

    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_DELAY        (SD),
        .NUM_STAGES         (NS),
        .CNT_W              (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_rst_req  (soft_rst_req),
        .rst_out       (rst_out),
        .ready         (ready),
        .state_o       (state_o)
`ifdef PLL_RST_LOSS_COUNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter: after posedge N, cyc == N
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input logic [2:0] r,
                             input logic rdy, input logic [1:0] st);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.r   = r;
        e.rdy = rdy;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef PLL_RST_LOSS_COUNT_EN
    task automatic bump_llc();
        if (exp_llc < (1 << CW) - 1) exp_llc++;
    endtask
`endif

    // Scoreboard monitor: compare expectations scheduled for this edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.at < cyc) begin
                check_val({e.tag, "_missed"}, 32'(cyc), 32'(e.at));
            end else begin
                check_val({e.tag, "_rst_out"}, 32'(rst_out), 32'(e.r));
                check_val({e.tag, "_ready"},   32'(ready),   32'(e.rdy));
                check_val({e.tag, "_state"},   32'(state_o), 32'(e.st));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        int s;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        pll_locked   = 1'b0;
        soft_rst_req = 1'b0;
`ifdef PLL_RST_LOSS_COUNT_EN
        exp_llc      = 0;
`endif

        // ---- Reset values ----
        tick(3);
        b = cyc;
        expect_at(b, "reset", 3'b111, 1'b0, 2'd0);
`ifdef PLL_RST_LOSS_COUNT_EN
        check_val("llc_reset", 32'(lock_loss_cnt), 32'(exp_llc));
`endif

        // ---- Clean lock: edge 1 is b+1 ----
        rst        = 1'b0;
        pll_locked = 1'b1;
        expect_at(b + 2,  "clean_e2",  3'b111, 1'b0, 2'd0);
        expect_at(b + 3,  "clean_e3",  3'b111, 1'b0, 2'd1);
        expect_at(b + 10, "clean_e10", 3'b111, 1'b0, 2'd1);
        expect_at(b + 11, "clean_e11", 3'b110, 1'b0, 2'd2);
        expect_at(b + 14, "clean_e14", 3'b110, 1'b0, 2'd2);
        expect_at(b + 15, "clean_e15", 3'b100, 1'b0, 2'd2);
        expect_at(b + 18, "clean_e18", 3'b100, 1'b0, 2'd2);
        expect_at(b + 19, "clean_e19", 3'b000, 1'b1, 2'd3);
        tick(21);

        // ---- Lock loss in RUN ----
        pll_locked = 1'b0;
        b = cyc;
        expect_at(b + 2, "runloss_e2", 3'b000, 1'b1, 2'd3);
        expect_at(b + 3, "runloss_e3", 3'b111, 1'b0, 2'd0);
        tick(3);
`ifdef PLL_RST_LOSS_COUNT_EN
        bump_llc();
        check_val("llc_runloss", 32'(lock_loss_cnt), 32'(exp_llc));
`endif
        tick(1);

        // ---- Lock drop after 5 cycles of STABILIZE ----
        pll_locked = 1'b1;
        b = cyc;
        expect_at(b + 3, "stabdrop_enter", 3'b111, 1'b0, 2'd1);
        expect_at(b + 7, "stabdrop_5cyc",  3'b111, 1'b0, 2'd1);
        tick(7);
        pll_locked = 1'b0;
        expect_at(b + 9,  "stabdrop_e9",  3'b111, 1'b0, 2'd1);
        expect_at(b + 10, "stabdrop_e10", 3'b111, 1'b0, 2'd0);
        tick(3);
`ifdef PLL_RST_LOSS_COUNT_EN
        bump_llc();
        check_val("llc_stabdrop", 32'(lock_loss_cnt), 32'(exp_llc));
`endif
        // fresh qualification must take the full 8 cycles again
        pll_locked = 1'b1;
        b2 = cyc;
        expect_at(b2 + 3,  "requal_e3",  3'b111, 1'b0, 2'd1);
        expect_at(b2 + 10, "requal_e10", 3'b111, 1'b0, 2'd1);
        expect_at(b2 + 11, "requal_e11", 3'b110, 1'b0, 2'd2);
        expect_at(b2 + 15, "requal_e15", 3'b100, 1'b0, 2'd2);
        tick(15);

        // ---- Soft request in RELEASE with rst_out=100 ----
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        s = cyc;
        expect_at(s,      "soft_e0",  3'b111, 1'b0, 2'd1);
        expect_at(s + 7,  "soft_e7",  3'b111, 1'b0, 2'd1);
        expect_at(s + 8,  "soft_e8",  3'b110, 1'b0, 2'd2);
        expect_at(s + 12, "soft_e12", 3'b100, 1'b0, 2'd2);
        expect_at(s + 15, "soft_e15", 3'b100, 1'b0, 2'd2);
        expect_at(s + 16, "soft_e16", 3'b000, 1'b1, 2'd3);
        tick(18);

        // ---- Simultaneous lock loss and soft request ----
        pll_locked = 1'b0;
        b = cyc;
        tick(2);
        soft_rst_req = 1'b1;
        expect_at(b + 2, "simul_e2", 3'b000, 1'b1, 2'd3);
        expect_at(b + 3, "simul_e3", 3'b111, 1'b0, 2'd0);
        expect_at(b + 5, "simul_e5", 3'b111, 1'b0, 2'd0);
        tick(1);
        soft_rst_req = 1'b0;
`ifdef PLL_RST_LOSS_COUNT_EN
        bump_llc();
        check_val("llc_simul", 32'(lock_loss_cnt), 32'(exp_llc));
`endif
        tick(3);

        // ---- Synchronous reset mid-RELEASE ----
        pll_locked = 1'b1;
        b = cyc;
        expect_at(b + 11, "midrel_e11", 3'b110, 1'b0, 2'd2);
        expect_at(b + 12, "midrel_e12", 3'b110, 1'b0, 2'd2);
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_at(b + 13, "srst_e13", 3'b111, 1'b0, 2'd0);
        // synchronizer was cleared too, so lock is re-seen two edges later
        expect_at(b + 15, "srst_e15", 3'b111, 1'b0, 2'd0);
        expect_at(b + 16, "srst_e16", 3'b111, 1'b0, 2'd1);
`ifdef PLL_RST_LOSS_COUNT_EN
        exp_llc = 0;
        check_val("llc_srst", 32'(lock_loss_cnt), 32'(exp_llc));
`endif
        tick(3);

        // ---- Five lock losses from STABILIZE (saturation with CNT_W=2) ----
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            b = cyc;
            expect_at(b + 2, "satloop_hold", 3'b111, 1'b0, 2'd1);
            expect_at(b + 3, "satloop_wait", 3'b111, 1'b0, 2'd0);
            tick(3);
`ifdef PLL_RST_LOSS_COUNT_EN
            bump_llc();
            check_val("llc_satloop", 32'(lock_loss_cnt), 32'(exp_llc));
`endif
            pll_locked = 1'b1;
            b = cyc;
            expect_at(b + 3, "satloop_stab", 3'b111, 1'b0, 2'd1);
            tick(3);
        end
`ifdef PLL_RST_LOSS_COUNT_EN
        check_val("llc_saturated", 32'(lock_loss_cnt), 32'd3);
`endif

        // drain the scoreboard
        tick(4);
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pll_reset_sequencer

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock-qualified reset sequencer placed directly downstream of the system PLL. Runs on the PLL's 65 MHz `outclk_0` and watches the asynchronous PLL `locked` output. It holds all downstream logic in reset until lock has been stable for a programmable time, then releases the per-stage resets one at a time. Loss of lock, or a software request, re-arms the whole sequence.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: cycles `locked_s` must stay high before release begins; must be ≥ 2.
- `STAGE_DELAY`, default 16: cycles between consecutive stage releases; must be ≥ 1.
- `NUM_STAGES`, default 3: number of reset outputs; must be ≥ 1.
- `CNT_W`, default 8: width of the lock-loss counter.

Ports:
- `clk` in 1: PLL `outclk_0`.
- `rst` in 1: synchronous, active-high.
- `pll_locked` in 1: PLL lock flag; asynchronous to `clk`.
- `soft_rst_req` in 1: single-cycle request, synchronous to `clk`, to re-run the sequence.
- `rst_out` out `NUM_STAGES`: active-high stage resets; bit 0 is released first.
- `ready` out 1: all stages released.
- `state_o` out 2: current FSM state, for debug.
- `lock_loss_cnt` out `CNT_W`: present only with the macro.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to produce `locked_s`.
- Reset values (while `rst` = 1): state WAIT_LOCK, `rst_out` all ones, `ready` 0, synchronizer FFs 0, all counters 0, `lock_loss_cnt` 0.
- FSM states and encoding: WAIT_LOCK = 0, STABILIZE = 1, RELEASE = 2, RUN = 3.
- **WAIT_LOCK:** `rst_out` all ones. If `locked_s` = 1, go to STABILIZE with `cnt` = 0.
- **STABILIZE:** `cnt` increments each cycle.
  - If `locked_s` = 0, go to WAIT_LOCK.
  - If `cnt` = `LOCK_STABLE_CYCLES`−1, go to RELEASE. On this same edge `rst_out[0]` drops and `dcnt` is set to 0.
- **RELEASE:** `dcnt` counts to `STAGE_DELAY`−1, then the next `rst_out` bit drops and `dcnt` wraps.
  - `ready` rises, and the state moves to RUN, on the same edge the bit `NUM_STAGES`−1 drops.
  - With `NUM_STAGES` = 1, STABILIZE goes directly to RUN.
- **RUN:** `ready` = 1 and `rst_out` = 0.
- Abort rules, applied in RELEASE or RUN:
  - `locked_s` = 0: on the next edge go to WAIT_LOCK, set `rst_out` all ones and `ready` 0.
  - `soft_rst_req` = 1: on the next edge go to STABILIZE with `cnt` = 0, set `rst_out` all ones and `ready` 0.
  - If both occur in the same cycle, lock loss wins.
  - `soft_rst_req` is ignored in WAIT_LOCK and STABILIZE.
- `rst_out` bits only ever deassert in ascending index order. Any abort reasserts all bits simultaneously.
- Counters are sized by `$clog2` of their terminal value and never wrap in use.

## Timing
- Take edge 1 as the first `clk` edge that samples `pll_locked` = 1.
  - `locked_s` is high after edge 2.
  - The state is STABILIZE after edge 3.
  - `rst_out[0]` is low after edge `LOCK_STABLE_CYCLES`+3.
  - `rst_out[i]` is low after edge `LOCK_STABLE_CYCLES`+3+i·`STAGE_DELAY`.
  - `ready` rises together with the last bit.
- Lock-loss latency: `rst_out` is all ones and `ready` is 0 after the 3rd edge that samples `pll_locked` = 0.
- Soft-request latency: 1 edge.
- A glitch on `pll_locked` shorter than one `clk` period may be missed. If it is captured, it restarts the qualification.
- `rst` mid-sequence takes effect on the next edge, with the reset values above.
- All outputs are registered.

## Configuration
- With `PLL_RST_LOSS_COUNT_EN` defined:
  - `lock_loss_cnt` exists.
  - It increments by 1 on every transition into WAIT_LOCK caused by `locked_s` = 0 while in STABILIZE, RELEASE or RUN.
  - It saturates at 2^`CNT_W`−1 and is cleared only by `rst`.
- Without the macro: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Package `pll_rst_pkg`: the FSM state typedef (2-bit enum) and the state encoding constants.
- Sub-module `sync_2ff`: 1-bit two-flop synchronizer with synchronous reset to 0. The unit is reusable for other CDC single-bit flags.

## Test plan
All scenarios use `LOCK_STABLE_CYCLES`=8, `STAGE_DELAY`=4, `NUM_STAGES`=3.

- **Clean lock:** raise `pll_locked` before edge 1 → `rst_out` becomes 3'b110 after edge 11, 3'b100 after edge 15, 3'b000 with `ready`=1 after edge 19; `state_o`=3.
- **Lock drop during STABILIZE:** drop `pll_locked` after 5 cycles of STABILIZE → return to WAIT_LOCK; `rst_out` stays 3'b111; no release until 8 fresh stable cycles.
- **Lock loss in RUN:** drop `pll_locked` → `rst_out`=3'b111 and `ready`=0 after the 3rd sampling edge; `lock_loss_cnt` goes 0→1 when the macro is defined.
- **Soft request in RELEASE with `rst_out`=3'b100:** pulse `soft_rst_req` → `rst_out`=3'b111 next edge, state STABILIZE; full release 8+1+8 edges later.
- **Simultaneous events:** lock loss and `soft_rst_req` in the same cycle → state WAIT_LOCK, not STABILIZE.
- **Sync reset mid-RELEASE, then saturation:** assert `rst` for 1 cycle → all outputs at reset values next edge. With `CNT_W`=2 and 5 lock losses, `lock_loss_cnt`=3.
